// File: rtl/banked_program_memory.sv
// rtl/banked_program_memory.sv - dual-port (fetch + data) banked word memory
//
// Purpose: NUM_BANKS single-port banks of BANK_WORDS 32-bit words shared by an
// instruction fetch port and a data load/store port. Each bank serves at most
// one access per cycle. On a same-bank collision the data port wins, except
// when fetch has already lost MAX_FETCH_STALL times in a row. Reads return
// one cycle after grant. Out-of-range accesses are granted and answered with
// a fault and zero data.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   if_req, if_addr                fetch request / word address [31:2]
//   if_gnt                         fetch accepted (combinational)
//   if_rvalid, if_instr, if_fault  fetch response, one cycle after grant
//   d_req, d_wen, d_addr,
//   d_wdata, d_be                  data request, write enable, address, data, byte enables
//   d_gnt                          data accepted (combinational)
//   d_rvalid, d_rdata, d_fault     data response, one cycle after grant
module banked_program_memory #(
  parameter int NUM_BANKS       = 4,
  parameter int BANK_WORDS      = 2048,
  parameter int MAX_FETCH_STALL = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_instr,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault
);

  localparam int          OFF_W       = $clog2(BANK_WORDS);
  localparam int          BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [30:0] TOTAL_WORDS = 31'(NUM_BANKS * BANK_WORDS);
  localparam logic [3:0]  STALL_MAX   = 4'(MAX_FETCH_STALL);

  logic [BANK_W-1:0] if_bank, d_bank;
  logic [OFF_W-1:0]  if_off, d_off;
  logic              if_oor, d_oor, conflict, fetch_prio;
  logic [3:0]        loss_q, loss_d;

  logic              if_vld_q, if_flt_q, d_vld_q, d_flt_q, d_wr_q;
  logic [BANK_W-1:0] if_bank_q, d_bank_q;
  logic [31:0]       bank_rd [NUM_BANKS];

  assign if_bank = if_addr[OFF_W +: BANK_W];
  assign d_bank  = d_addr[OFF_W +: BANK_W];
  assign if_off  = if_addr[OFF_W-1:0];
  assign d_off   = d_addr[OFF_W-1:0];
  assign if_oor  = {1'b0, if_addr} >= TOTAL_WORDS;
  assign d_oor   = {1'b0, d_addr} >= TOTAL_WORDS;

  // Out-of-range accesses never touch a bank, so they cannot collide.
  assign conflict   = if_req && d_req && !if_oor && !d_oor && (if_bank == d_bank);
  assign fetch_prio = (loss_q == STALL_MAX);

  always_comb begin
    if_gnt = if_req && (!conflict || fetch_prio);
    d_gnt  = d_req && (!conflict || !fetch_prio);
    loss_d = loss_q;
    if (!if_req || if_gnt) begin
      loss_d = 4'd0;
    end else if (loss_q != STALL_MAX) begin
      loss_d = loss_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_vld_q  <= 1'b0;
      if_flt_q  <= 1'b0;
      if_bank_q <= '0;
      d_vld_q   <= 1'b0;
      d_flt_q   <= 1'b0;
      d_wr_q    <= 1'b0;
      d_bank_q  <= '0;
      loss_q    <= 4'd0;
    end else begin
      if_vld_q <= if_gnt;
      if_flt_q <= if_gnt && if_oor;
      d_vld_q  <= d_gnt;
      d_flt_q  <= d_gnt && d_oor;
      d_wr_q   <= d_gnt && d_wen;
      if (if_gnt) if_bank_q <= if_bank;
      if (d_gnt)  d_bank_q  <= d_bank;
      loss_q   <= loss_d;
    end
  end

  // Each bank owns one read register; the arbiter guarantees at most one
  // port hits a bank per cycle, so the register is unambiguous.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [31:0] mem [BANK_WORDS];
    logic [31:0] rd_q;
    logic        d_hit, i_hit;

    assign d_hit = d_gnt && !d_oor && (d_bank == BANK_W'(b));
    assign i_hit = if_gnt && !if_oor && (if_bank == BANK_W'(b));

    // Contents are never cleared; the reset term only blocks a write whose
    // edge coincides with reset assertion.
    always_ff @(posedge clk or posedge reset) begin
      if (!reset) begin
        if (d_hit && d_wen) begin
          for (int n = 0; n < 4; n++) begin
            if (d_be[n]) mem[d_off][8*n +: 8] <= d_wdata[8*n +: 8];
          end
        end else if (d_hit) begin
          rd_q <= mem[d_off];
        end else if (i_hit) begin
          rd_q <= mem[if_off];
        end
      end
    end

    assign bank_rd[b] = rd_q;
  end

  assign if_rvalid = if_vld_q;
  assign if_fault  = if_vld_q && if_flt_q;
  assign if_instr  = (if_vld_q && !if_flt_q) ? bank_rd[if_bank_q] : 32'd0;
  assign d_rvalid  = d_vld_q;
  assign d_fault   = d_vld_q && d_flt_q;
  assign d_rdata   = (d_vld_q && !d_flt_q && !d_wr_q) ? bank_rd[d_bank_q] : 32'd0;

endmodule

// File: tb/tb_banked_program_memory.sv
// tb/tb_banked_program_memory.sv - self-checking bench for banked_program_memory
module tb_banked_program_memory;
  localparam int NB = 4;
  localparam int BW = 2048;
  localparam int MS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_wen;
  logic [29:0] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, if_fault, d_gnt, d_rvalid, d_fault;
  logic [31:0] if_instr, d_rdata;

  always #5 clk = ~clk;

  banked_program_memory #(.NUM_BANKS(NB), .BANK_WORDS(BW), .MAX_FETCH_STALL(MS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_instr(if_instr), .if_fault(if_fault),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault)
  );

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] model [int];
  int          loss = 0;
  logic        last_ig, last_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: drive, check grants against the arbitration rules,
  // cross the edge, then check the response against the word-level model.
  task automatic cyc(input logic ir, input logic [29:0] ia, input logic dr, input logic dw,
                     input logic [29:0] da, input logic [31:0] wd, input logic [3:0] be);
    bit          iin, din, conf, eig, edg, iknown, dknown;
    int          ib, db;
    logic [31:0] ei, ed, w;
    if_req = ir; if_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = wd; d_be = be;
    #1;
    iin  = int'(ia) < NB * BW;
    din  = int'(da) < NB * BW;
    ib   = int'(ia) / BW;
    db   = int'(da) / BW;
    conf = ir && dr && iin && din && (ib == db);
    eig  = ir && (!conf || loss == MS);
    edg  = dr && (!conf || loss != MS);
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
    last_ig = if_gnt;
    last_dg = d_gnt;
    iknown = !(eig && iin) || model.exists(int'(ia));
    ei     = (eig && iin && iknown) ? model[int'(ia)] : 32'd0;
    dknown = !(edg && din && !dw) || model.exists(int'(da));
    ed     = (edg && din && !dw && dknown) ? model[int'(da)] : 32'd0;
    if (!ir || eig) loss = 0;
    else if (loss < MS) loss++;
    @(posedge clk); #1;
    if (edg && dw && din) begin
      if (model.exists(int'(da))) begin
        w = model[int'(da)];
        for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = wd[8*n +: 8];
        model[int'(da)] = w;
      end else if (be == 4'hF) begin
        model[int'(da)] = wd;
      end
    end
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, eig});
    chk("if_fault", {31'd0, if_fault}, {31'd0, eig && !iin});
    if (iknown) chk("if_instr", if_instr, ei);
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, edg});
    chk("d_fault", {31'd0, d_fault}, {31'd0, edg && !din});
    if (dknown) chk("d_rdata", d_rdata, ed);
  endtask

  function automatic logic [29:0] rand_addr();
    int b;
    b = $urandom_range(0, 4);
    if (b == 4) return ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFF : 30'(NB * BW + $urandom_range(0, 100));
    return 30'(b * BW + $urandom_range(0, 7));
  endfunction

  initial begin
    int fg, dg;
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    #3;
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_faults", {30'd0, if_fault, d_fault}, 32'd0);
    chk("rst_gnt_idle", {30'd0, if_gnt, d_gnt}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Known contents for the random working set.
    for (int b = 0; b < NB; b++)
      for (int o = 0; o < 8; o++)
        cyc(0, 0, 1, 1, 30'(b * BW + o), $urandom, 4'hF);

    cyc(0, 0, 1, 1, 30'h0800, 32'hDEADBEEF, 4'hF);
    cyc(0, 0, 1, 0, 30'h0800, 0, 4'h0);
    chk("rd_0800", d_rdata, 32'hDEADBEEF);

    cyc(0, 0, 1, 1, 30'h0010, 32'h11223344, 4'hF);
    cyc(0, 0, 1, 1, 30'h0010, 32'h0000AA00, 4'h2);
    cyc(0, 0, 1, 0, 30'h0010, 0, 4'h0);
    chk("rd_0010_be", d_rdata, 32'h1122AA44);

    cyc(1, 30'h0005, 1, 0, 30'h1805, 0, 4'h0);
    chk("diff_bank_both_gnt", {30'd0, last_ig, last_dg}, 32'd3);

    cyc(0, 0, 0, 0, 0, 0, 4'h0);
    fg = 0; dg = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 30'h0001, 1, 0, 30'h0003, 0, 4'h0);
      fg += int'(last_ig);
      dg += int'(last_dg);
    end
    chk("stall_fetch_grants", 32'(fg), 32'd2);
    chk("stall_data_grants", 32'(dg), 32'd6);

    cyc(0, 0, 1, 1, 30'h2000, 32'hCAFEF00D, 4'hF);
    for (int b = 0; b < NB; b++) cyc(0, 0, 1, 0, 30'(b * BW), 0, 4'h0);

    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 7) != 0, rand_addr(), $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
          rand_addr(), $urandom, 4'($urandom_range(0, 15)));

    // Reset in the middle of a read burst, plus a write held across an edge
    // while reset is asserted.
    for (int i = 0; i < 3; i++) cyc(1, 30'(BW + i), 1, 0, 30'(2 * BW + i), 0, 4'h0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("mid_rst_if_instr", if_instr, 32'd0);
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    if_req = 0; d_req = 1; d_wen = 1; d_addr = 30'h0003; d_wdata = 32'h0BAD_0BAD; d_be = 4'hF;
    @(posedge clk); #1;
    d_req = 0; d_wen = 0;
    loss = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    cyc(1, 30'h0003, 1, 0, 30'h0803, 0, 4'h0);
    cyc(0, 0, 0, 0, 0, 0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/banked_program_memory.md
BANKED_PROGRAM_MEMORY -- requirements
Module: banked_program_memory

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of single-port word banks (1..16).
REQ-002 SHALL have parameter BANK_WORDS, default 2048, words per bank; power of two.
REQ-003 SHALL have parameter MAX_FETCH_STALL, default 3, consecutive conflict losses before fetch gets priority (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port if_req  input  1  instruction fetch request.
REQ-007 SHALL have port if_addr  input  30 [31:2]  fetch word address.
REQ-008 SHALL have port if_gnt  output  1  fetch accepted this cycle (combinational).
REQ-009 SHALL have port if_rvalid  output  1  if_instr valid.
REQ-010 SHALL have port if_instr  output  32  fetched word.
REQ-011 SHALL have port d_req  input  1  data access request.
REQ-012 SHALL have port d_wen  input  1  1 = write, 0 = read.
REQ-013 SHALL have port d_addr  input  30 [31:2]  data word address.
REQ-014 SHALL have port d_wdata  input  32  write data.
REQ-015 SHALL have port d_be  input  4  byte enables; bit n writes byte n.
REQ-016 SHALL have port d_gnt  output  1  data access accepted this cycle (combinational).
REQ-017 SHALL have port d_rvalid  output  1  response for accepted data access (read or write).
REQ-018 SHALL have port d_rdata  output  32  read data.
REQ-019 SHALL have port d_fault  output  1  accepted data access was out of range; qualified by d_rvalid.
REQ-020 SHALL have port if_fault  output  1  accepted fetch was out of range; qualified by if_rvalid.

Function
REQ-021 SHALL map word address A to bank A / BANK_WORDS, offset A mod BANK_WORDS; A >= NUM_BANKS*BANK_WORDS is out of range.
REQ-022 SHALL allow each bank at most one access (read or write) per cycle.
REQ-023 SHALL grant both ports in the same cycle when they target different banks or either is out of range.
REQ-024 SHALL on same-bank conflict grant data port and deny fetch, unless fetch-loss counter == MAX_FETCH_STALL, then grant fetch and deny data.
REQ-025 SHALL increment fetch-loss counter on each denied fetch, clear it on each granted fetch or cycle with if_req=0; saturate at MAX_FETCH_STALL.
REQ-026 SHALL hold gnt low when corresponding req is low.
REQ-027 SHALL return granted reads with exactly 1-cycle latency: rvalid high the cycle after gnt, for one cycle.
REQ-028 SHALL register the selected bank index per port and mux outputs from the registered index.
REQ-029 SHALL apply granted writes at the grant edge with byte enables; d_rvalid pulses next cycle, d_rdata = 0.
REQ-030 SHALL for out-of-range accesses grant immediately, suppress any bank write, return rdata/instr = 0 with fault = 1.
REQ-031 SHALL return old word on a read to the same address as a same-cycle write from the other port (read-before-write); only data port writes.
REQ-032 SHALL drive fault = 0 and rdata/instr = 0 whenever rvalid = 0.
REQ-033 SHALL support back-to-back granted requests every cycle per port with no bubbles.
REQ-034 SHALL leave bank contents uninitialised by reset (no clearing).

Reset
REQ-035 SHALL on reset asynchronously clear if_rvalid, d_rvalid, if_fault, d_fault, fetch-loss counter, registered bank indices; if_instr, d_rdata = 0.
REQ-036 SHALL discard any access granted in the cycle reset asserts: no rvalid after reset release; a write whose edge coincides with reset is not performed.
REQ-037 SHALL accept requests on the first rising edge after reset deasserts.

Verification
REQ-038 SHALL cover: write 0xDEADBEEF d_be=0xF to 0x0800, then read 0x0800 -> d_rvalid one cycle after gnt, d_rdata=0xDEADBEEF, d_fault=0.
REQ-039 SHALL cover: write 0x11223344 then d_be=0x2 write 0x0000AA00 to 0x0010 -> read returns 0x1122AA44.
REQ-040 SHALL cover: fetch 0x0005 and data read 0x1805 same cycle -> both gnt, both rvalid next cycle.
REQ-041 SHALL cover: continuous fetch and data both on bank 0 -> fetch denied 3 cycles, granted 4th with data denied; pattern repeats.
REQ-042 SHALL cover: data write to 0x2000 (defaults) -> d_gnt=1, d_fault=1, d_rdata=0, no bank modified.
REQ-043 SHALL cover: reset asserted mid-burst of granted reads -> rvalids drop asynchronously, none reappear after release.
